// File: rtl/perf_event_counter_bank_pkg.sv
// perf_pkg: shared types and constants for the performance-monitor bank.
//   perf_state_e      : controller states (IDLE, COUNT, DUMP, DONE)
//   EV_*              : event_in bit positions of the standard core events
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } perf_state_e;

    localparam int EV_INST  = 0;
    localparam int EV_ICREQ = 1;
    localparam int EV_ICHIT = 2;
    localparam int EV_DCREQ = 3;
    localparam int EV_DCHIT = 4;

endpackage

// File: rtl/perf_event_counter_bank_if.sv
// Dump streaming port of the performance-monitor bank.
//   dump_valid : word available (source)
//   dump_ready : consumer accepts word (sink)
//   dump_data  : counter value
//   dump_idx   : 0 = cycle counter, k = event k-1
//   dump_last  : current word is the final one
interface perf_event_counter_bank_if #(
    parameter int CNT_WIDTH = 32,
    parameter int IDX_W     = 4
);
    logic                 dump_valid;
    logic                 dump_ready;
    logic [CNT_WIDTH-1:0] dump_data;
    logic [IDX_W-1:0]     dump_idx;
    logic                 dump_last;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_idx,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_idx,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/perf_event_counter_bank_cell.sv
// perf_counter_cell: one CNT_WIDTH event counter with sticky overflow flag.
//   clk, rst : clock, synchronous active-high reset
//   inc      : add one this cycle
//   clr      : zero count and ovf (wins over inc)
//   count    : current value
//   ovf      : set when an increment arrives at all-ones; held until clr/rst
module perf_counter_cell #(
    parameter int CNT_WIDTH = 32,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ovf
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (&count) begin
                ovf <= 1'b1;
                if (!SATURATE) begin
                    count <= '0;
                end
            end else begin
                count <= count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/perf_event_counter_bank.sv
// perf_event_counter_bank: cycle counter plus NUM_EVENTS event counters.
// Counts while running, freezes on halt and streams the snapshot out.
//   clk, rst   : clock, synchronous active-high reset
//   start      : IDLE -> COUNT
//   clear      : zero counters/ovf (ignored during DUMP); DONE -> IDLE
//   event_in   : per-cycle event strobes
//   halt       : COUNT -> DUMP (halt cycle is still counted)
//   rd_sel     : read index, 0 = cycles, i+1 = event i, out of range reads 0
//   rd_data    : registered read data, one cycle latency
//   ovf        : sticky overflow flags, bit 0 = cycles, bit i+1 = event i
//   dump       : valid/ready snapshot stream (master side)
//   busy, done : in COUNT/DUMP, in DONE
//
// state | meaning
// IDLE  | counters held, waiting for start
// COUNT | cycle and event counters running
// DUMP  | counters frozen, streaming NUM_EVENTS+1 words
// DONE  | counters frozen, waiting for clear
module perf_event_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int SATURATE   = 1,
    parameter int IDX_W      = $clog2(NUM_EVENTS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      clear,
    input  logic [NUM_EVENTS-1:0]     event_in,
    input  logic                      halt,
    input  logic [IDX_W-1:0]          rd_sel,
    output logic [CNT_WIDTH-1:0]      rd_data,
    output logic [NUM_EVENTS:0]       ovf,
    perf_event_counter_bank_if.master dump,
    output logic                      busy,
    output logic                      done
);

    localparam int NUM_WORDS = NUM_EVENTS + 1;

    perf_state_e          state;
    logic [CNT_WIDTH-1:0] cnt [NUM_WORDS];
    logic [NUM_WORDS-1:0] inc;
    logic                 clr_cnt;
    logic [CNT_WIDTH-1:0] rd_next;
    logic [CNT_WIDTH-1:0] dump_word;

    // Clear is blocked in DUMP so the snapshot being streamed cannot change.
    assign clr_cnt = clear && (state != DUMP);
    assign inc     = (state == COUNT) ? {event_in, 1'b1} : '0;

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_cell
        perf_counter_cell #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE != 0)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc[g]),
            .clr   (clr_cnt),
            .count (cnt[g]),
            .ovf   (ovf[g])
        );
    end

    always_comb begin
        rd_next   = '0;
        dump_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rd_sel == IDX_W'(i)) begin
                rd_next = cnt[i];
            end
            if (dump.dump_idx == IDX_W'(i)) begin
                dump_word = cnt[i];
            end
        end
    end

    // Counters are frozen in DUMP, so a mux on the registered index is stable
    // under backpressure.
    assign dump.dump_data = dump_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rd_data         <= '0;
            dump.dump_valid <= 1'b0;
            dump.dump_idx   <= '0;
            dump.dump_last  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            rd_data <= rd_next;
            case (state)
                IDLE: begin
                    if (!clear && start) begin
                        state <= COUNT;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (halt) begin
                        state           <= DUMP;
                        dump.dump_valid <= 1'b1;
                        dump.dump_idx   <= '0;
                        dump.dump_last  <= 1'b0;
                    end
                end
                DUMP: begin
                    if (dump.dump_valid && dump.dump_ready) begin
                        if (dump.dump_last) begin
                            state           <= DONE;
                            dump.dump_valid <= 1'b0;
                            dump.dump_last  <= 1'b0;
                            dump.dump_idx   <= '0;
                            busy            <= 1'b0;
                            done            <= 1'b1;
                        end else begin
                            dump.dump_idx  <= dump.dump_idx + IDX_W'(1);
                            dump.dump_last <= (dump.dump_idx == IDX_W'(NUM_EVENTS - 1));
                        end
                    end
                end
                DONE: begin
                    if (clear) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_event_counter_bank.sv
module tb_perf_event_counter_bank;
    import perf_pkg::*;

    localparam int NE = 8;
    localparam int IW = 4;
    localparam int NW = NE + 1;

    localparam int P_IDLE  = 0;
    localparam int P_COUNT = 1;
    localparam int P_DUMP  = 2;
    localparam int P_DONE  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, clear, halt, dump_ready;
    logic [NE-1:0] event_in;
    logic [IW-1:0] rd_sel;

    logic [31:0] rd0;
    logic [7:0]  rd1, rd2;
    logic [NE:0] ovf0, ovf1, ovf2;
    logic        busy0, busy1, busy2, done0, done1, done2;

    perf_event_counter_bank_if #(.CNT_WIDTH(32), .IDX_W(IW)) if0 ();
    perf_event_counter_bank_if #(.CNT_WIDTH(8),  .IDX_W(IW)) if1 ();
    perf_event_counter_bank_if #(.CNT_WIDTH(8),  .IDX_W(IW)) if2 ();
    assign if0.dump_ready = dump_ready;
    assign if1.dump_ready = dump_ready;
    assign if2.dump_ready = dump_ready;

    perf_event_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(32), .SATURATE(1)) u_w32 (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .event_in(event_in),
        .halt(halt), .rd_sel(rd_sel), .rd_data(rd0), .ovf(ovf0), .dump(if0),
        .busy(busy0), .done(done0));
    perf_event_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(8), .SATURATE(1)) u_s8 (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .event_in(event_in),
        .halt(halt), .rd_sel(rd_sel), .rd_data(rd1), .ovf(ovf1), .dump(if1),
        .busy(busy1), .done(done1));
    perf_event_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(8), .SATURATE(0)) u_r8 (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .event_in(event_in),
        .halt(halt), .rd_sel(rd_sel), .rd_data(rd2), .ovf(ovf2), .dump(if2),
        .busy(busy2), .done(done2));

    // Reference model: true (unbounded) event totals since the last clear.
    typedef struct {
        int     idx;
        longint n;
    } word_t;

    longint true_cnt [NW];
    int     phase;
    int     word_pos;
    word_t  exp_q [$];
    int     checks = 0;
    int     errors = 0;

    function automatic longint view(longint n, int w, bit sat);
        longint lim;
        lim = (longint'(1) << w) - 1;
        if (n <= lim) return n;
        return sat ? lim : (n % (lim + 1));
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic zero_model();
        for (int k = 0; k < NW; k++) true_cnt[k] = 0;
    endtask

    task automatic model_edge(logic st, logic cl, logic hl, logic [NE-1:0] ev);
        case (phase)
            P_IDLE: begin
                if (cl) zero_model();
                else if (st) phase = P_COUNT;
            end
            P_COUNT: begin
                if (cl) zero_model();
                else begin
                    true_cnt[0]++;
                    for (int i = 0; i < NE; i++) if (ev[i]) true_cnt[i+1]++;
                end
                if (hl) begin
                    phase    = P_DUMP;
                    word_pos = 0;
                    for (int k = 0; k < NW; k++) exp_q.push_back('{k, true_cnt[k]});
                end
            end
            P_DUMP: begin
                if (dump_ready) begin
                    word_pos++;
                    if (word_pos == NW) phase = P_DONE;
                end
            end
            default: begin
                if (cl) begin
                    zero_model();
                    phase = P_IDLE;
                end
            end
        endcase
    endtask

    task automatic check_outputs(longint exp_rd);
        logic [NE:0] e_ovf8;
        for (int k = 0; k < NW; k++) e_ovf8[k] = (true_cnt[k] > 255);
        chk("rd_data w32", longint'(rd0), view(exp_rd, 32, 1'b1));
        chk("rd_data sat8", longint'(rd1), view(exp_rd, 8, 1'b1));
        chk("rd_data wrap8", longint'(rd2), view(exp_rd, 8, 1'b0));
        chk("ovf w32", longint'(ovf0), 0);
        chk("ovf sat8", longint'(ovf1), longint'(e_ovf8));
        chk("ovf wrap8", longint'(ovf2), longint'(e_ovf8));
        chk("busy", longint'(busy0), longint'(phase == P_COUNT || phase == P_DUMP));
        chk("done", longint'(done0), longint'(phase == P_DONE));
        chk("dump_valid", longint'(if0.dump_valid), longint'(phase == P_DUMP));
        chk("busy/done copies", longint'({busy1, busy2, done1, done2}),
            longint'({busy0, busy0, done0, done0}));
        if (phase == P_DUMP) begin
            chk("dump_idx position", longint'(if0.dump_idx), longint'(word_pos));
            chk("dump_last position", longint'(if0.dump_last), longint'(word_pos == NE));
        end
    endtask

    // Called at a falling edge; drives one cycle and checks after the edge.
    task automatic cycle(logic st, logic cl, logic hl, logic [NE-1:0] ev, logic [IW-1:0] sel);
        longint exp_rd;
        start    = st;
        clear    = cl;
        halt     = hl;
        event_in = ev;
        rd_sel   = sel;
        exp_rd   = (int'(sel) < NW) ? true_cnt[sel] : 0;
        @(posedge clk);
        model_edge(st, cl, hl, ev);
        @(negedge clk);
        check_outputs(exp_rd);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        clear      = 1'b0;
        halt       = 1'b0;
        event_in   = '0;
        dump_ready = 1'b0;
        @(posedge clk);
        zero_model();
        phase    = P_IDLE;
        word_pos = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check_outputs(0);
        chk("reset dump_idx", longint'(if0.dump_idx), 0);
        chk("reset dump_last", longint'(if0.dump_last), 0);
    endtask

    task automatic random_count(int n, bit with_clear);
        for (int i = 0; i < n; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  with_clear && ($urandom_range(0, 15) == 0),
                  1'b0, NE'($urandom), IW'($urandom_range(0, 15)));
        end
    endtask

    task automatic run_dump(bit bp, int stop_at);
        int budget;
        int stall;
        budget = 300;
        stall  = 0;
        while (phase == P_DUMP && budget > 0) begin
            if (stop_at >= 0 && word_pos == stop_at) return;
            if (!bp) dump_ready = 1'b1;
            else if (word_pos == 2 && stall < 3) begin
                dump_ready = 1'b0;
                stall++;
            end else dump_ready = ($urandom_range(0, 3) != 0);
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), NE'($urandom), IW'($urandom_range(0, 15)));
            budget--;
        end
        if (phase == P_DUMP) begin
            checks++;
            errors++;
            $display("FAIL dump timeout: still at word %0d after budget", word_pos);
        end else begin
            chk("dump words remaining", longint'(exp_q.size()), 0);
        end
        dump_ready = 1'b0;
    endtask

    // Monitor: pops the expected snapshot on every handshake, and checks that
    // a stalled word holds its index and data.
    initial begin
        word_t       w;
        logic        stalled;
        logic [3:0]  s_idx;
        logic [31:0] s_data;
        stalled = 1'b0;
        s_idx   = '0;
        s_data  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst || !if0.dump_valid) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall idx hold", longint'(if0.dump_idx), longint'(s_idx));
                    chk("stall data hold", longint'(if0.dump_data), longint'(s_data));
                end
                if (dump_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dump unexpected word: idx %0d data %0d",
                                 if0.dump_idx, if0.dump_data);
                    end else begin
                        w = exp_q.pop_front();
                        chk("dump_idx", longint'(if0.dump_idx), longint'(w.idx));
                        chk("dump_data w32", longint'(if0.dump_data), view(w.n, 32, 1'b1));
                        chk("dump_data sat8", longint'(if1.dump_data), view(w.n, 8, 1'b1));
                        chk("dump_data wrap8", longint'(if2.dump_data), view(w.n, 8, 1'b0));
                        chk("dump_last", longint'(if0.dump_last), longint'(w.idx == NE));
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    s_idx   = if0.dump_idx;
                    s_data  = if0.dump_data;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NE-1:0] ev_inst;
        logic [NE-1:0] ev_mix;
        ev_inst = NE'(1 << EV_INST);
        ev_mix  = NE'((1 << EV_INST) | (1 << EV_ICREQ) | (1 << EV_ICHIT) |
                      (1 << EV_DCREQ) | (1 << EV_DCHIT));

        do_reset();

        // Ten instructions, halt on the tenth, free-flowing dump.
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, (i == 9), ev_inst, IW'(i % NW));
        run_dump(1'b0, -1);

        // Random counting with occasional clears, dump under backpressure.
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        random_count(40, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, NE'($urandom), '0);
        run_dump(1'b1, -1);

        // 300 pulses on event 0: saturate vs wrap at 8 bits.
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 300; i++)
            cycle(1'b0, 1'b0, 1'b0, ev_inst | (NE'($urandom) & 8'hF0), IW'(1));
        cycle(1'b0, 1'b0, 1'b0, '0, IW'(1));

        // Clear against an all-ones event cycle, then count again from zero.
        cycle(1'b0, 1'b1, 1'b0, 8'hFF, IW'(1));
        cycle(1'b0, 1'b0, 1'b0, ev_mix, IW'(1));
        cycle(1'b0, 1'b0, 1'b0, '0, IW'(1));
        random_count(20, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, NE'($urandom), '0);
        run_dump(1'b1, -1);

        // Halt together with clear: all-zero snapshot, then back to IDLE.
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        random_count(15, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'hFF, '0);
        run_dump(1'b0, -1);
        cycle(1'b0, 1'b1, 1'b0, '0, '0);

        // Reset while the dump sits on word 4.
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        random_count(12, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, NE'($urandom), '0);
        run_dump(1'b0, 4);
        chk("mid-dump position", longint'(if0.dump_idx), 4);
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, '0, IW'(9));
        cycle(1'b0, 1'b0, 1'b0, '0, IW'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
